// File: rtl/ps2_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ps2_pkg
// Description : Shared types and scan-code constants for the PS/2 keyboard path.
// Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } frame_state_t;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    // Keyboard status/acknowledge bytes that never represent a key.
    localparam int         PS2_NUM_DISCARD = 7;
    localparam logic [7:0] PS2_DISCARD [PS2_NUM_DISCARD] =
        '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};

    function automatic logic is_discard(input logic [7:0] b);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < PS2_NUM_DISCARD; i++) begin
            if (b == PS2_DISCARD[i]) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_rx_frame.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ps2_rx_frame
// Description : PS/2 line conditioning, 11-bit frame receiver with parity,
//               stop-bit and watchdog checking, and a saturating error count.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 200000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic [7:0] frame_errors
);

    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int WW = $clog2(TIMEOUT + 1);

    logic [1:0]    r_clk_sync;
    logic [1:0]    r_dat_sync;
    logic          r_filt_clk;
    logic [FW-1:0] r_filt_cnt;

    frame_state_t  r_state;
    logic [2:0]    r_bitcnt;
    logic [7:0]    r_shift;
    logic          r_parity;
    logic [WW-1:0] r_wdog;
    logic          r_byte_valid;
    logic [7:0]    r_frame_errors;

    logic          w_filt_done;
    logic          w_strobe;
    logic          w_data;
    logic [7:0]    w_err_next;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_clk_sync <= 2'b11;
            r_dat_sync <= 2'b11;
            r_filt_clk <= 1'b1;
            r_filt_cnt <= '0;
        end else begin
            r_clk_sync <= {r_clk_sync[0], ps2_clk};
            r_dat_sync <= {r_dat_sync[0], ps2_data};
            if (r_clk_sync[1] != r_filt_clk) begin
                if (w_filt_done) begin
                    r_filt_clk <= r_clk_sync[1];
                    r_filt_cnt <= '0;
                end else begin
                    r_filt_cnt <= r_filt_cnt + 1'b1;
                end
            end else begin
                r_filt_cnt <= '0;
            end
        end
    end

    // The strobe fires in the same cycle the filtered clock commits to low.
    assign w_filt_done = (r_filt_cnt == FW'(FILTER_LEN - 1));
    assign w_strobe    = r_filt_clk & ~r_clk_sync[1] & w_filt_done;
    assign w_data      = r_dat_sync[1];
    assign w_err_next  = r_frame_errors + {7'd0, (r_frame_errors != 8'hFF)};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= IDLE;
            r_bitcnt       <= '0;
            r_shift        <= '0;
            r_parity       <= 1'b0;
            r_wdog         <= '0;
            r_byte_valid   <= 1'b0;
            r_frame_errors <= '0;
        end else begin
            r_byte_valid <= 1'b0;
            if (w_strobe) begin
                r_wdog <= '0;
                case (r_state)
                    IDLE: begin
                        if (!w_data) begin
                            r_state  <= DATA;
                            r_bitcnt <= '0;
                        end
                    end
                    DATA: begin
                        r_shift  <= {w_data, r_shift[7:1]};
                        r_bitcnt <= r_bitcnt + 3'd1;
                        if (r_bitcnt == 3'd7) r_state <= PARITY;
                    end
                    PARITY: begin
                        r_parity <= w_data;
                        r_state  <= STOP;
                    end
                    STOP: begin
                        r_state <= IDLE;
                        if (w_data && (^{r_shift, r_parity}))
                            r_byte_valid <= 1'b1;
                        else
                            r_frame_errors <= w_err_next;
                    end
                    default: r_state <= IDLE;
                endcase
            end else if (r_state != IDLE) begin
                if (r_wdog == WW'(TIMEOUT - 1)) begin
                    r_state        <= IDLE;
                    r_wdog         <= '0;
                    r_frame_errors <= w_err_next;
                end else begin
                    r_wdog <= r_wdog + 1'b1;
                end
            end
        end
    end

    assign byte_valid   = r_byte_valid;
    assign rx_byte      = r_shift;
    assign frame_errors = r_frame_errors;

endmodule
`default_nettype wire

// File: rtl/ps2_keyboard.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ps2_keyboard
// Description : Decodes make/break/E0 scan-code sequences into the currently
//               held key word read by the CPU.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_keyboard
    import ps2_pkg::*;
#(
    parameter int Dbits      = 32,
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 200000
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ps2_clk,
    input  logic             ps2_data,
    output logic [Dbits-1:0] keyb_char,
    output logic             key_event,
    output logic [7:0]       frame_errors
);

    logic             w_byte_valid;
    logic [7:0]       w_rx_byte;
    logic [8:0]       w_code;

    logic [Dbits-1:0] r_keyb_char;
    logic             r_key_event;
    logic             r_ext_pending;
    logic             r_brk_pending;

    ps2_rx_frame #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT    (TIMEOUT)
    ) u_rx (
        .clock        (clock),
        .reset_n      (reset_n),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .byte_valid   (w_byte_valid),
        .rx_byte      (w_rx_byte),
        .frame_errors (frame_errors)
    );

    assign w_code = {r_ext_pending, w_rx_byte};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_keyb_char   <= '0;
            r_key_event   <= 1'b0;
            r_ext_pending <= 1'b0;
            r_brk_pending <= 1'b0;
        end else begin
            r_key_event <= 1'b0;
            if (w_byte_valid) begin
                if (w_rx_byte == PS2_EXT) begin
                    r_ext_pending <= 1'b1;
                end else if (w_rx_byte == PS2_BRK) begin
                    r_brk_pending <= 1'b1;
                end else begin
                    r_ext_pending <= 1'b0;
                    r_brk_pending <= 1'b0;
                    if (!is_discard(w_rx_byte)) begin
                        if (!r_brk_pending) begin
                            r_keyb_char <= Dbits'(w_code);
                            r_key_event <= 1'b1;
                        end else if (w_code == r_keyb_char[8:0]) begin
                            // Only releasing the held key clears it.
                            r_keyb_char <= '0;
                            r_key_event <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign keyb_char = r_keyb_char;
    assign key_event = r_key_event;

endmodule
`default_nettype wire

// File: tb/tb_ps2_keyboard.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_ps2_keyboard
// Description : Scoreboard bench for ps2_keyboard with a scan-code model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_keyboard;

    localparam int DBITS = 32;
    localparam int FLEN  = 8;
    localparam int TMO   = 2000;

    logic             clock    = 1'b0;
    logic             reset_n  = 1'b1;
    logic             ps2_clk  = 1'b1;
    logic             ps2_data = 1'b1;
    logic [DBITS-1:0] keyb_char;
    logic             key_event;
    logic [7:0]       frame_errors;

    int checks = 0;
    int errors = 0;

    logic [DBITS-1:0] exp_q[$];
    logic [8:0]       m_held = '0;
    bit               m_ext  = 1'b0;
    bit               m_brk  = 1'b0;
    int               m_err  = 0;

    always #5 clock = ~clock;

    ps2_keyboard #(
        .Dbits      (DBITS),
        .FILTER_LEN (FLEN),
        .TIMEOUT    (TMO)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .keyb_char    (keyb_char),
        .key_event    (key_event),
        .frame_errors (frame_errors)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every key_event must match the oldest predicted word.
    always @(negedge clock) begin
        if (reset_n && key_event) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_key_event: got keyb_char %h, expected no event", keyb_char);
            end else begin
                check("key_event_value", keyb_char, exp_q.pop_front());
            end
        end
    end

    // Reference behaviour of one received frame at scan-code level.
    task automatic model_frame(input logic [7:0] b, input bit good);
        logic [8:0] code;
        if (!good) begin
            if (m_err < 255) m_err++;
            return;
        end
        if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else begin
            if (!(b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF})) begin
                code = {m_ext, b};
                if (!m_brk) begin
                    m_held = code;
                    exp_q.push_back(DBITS'(code));
                end else if (code == m_held) begin
                    m_held = '0;
                    exp_q.push_back('0);
                end
            end
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clock);
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        wait_cycles(10);
        ps2_clk = 1'b0;
        wait_cycles(25);
        ps2_clk = 1'b1;
        wait_cycles(15);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        logic par;
        par = (~^b) ^ bad_par;
        model_frame(b, !bad_par && !bad_stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(par);
        send_bit(!bad_stop);
        ps2_data = 1'b1;
        wait_cycles(20);
    endtask

    task automatic check_state(input string name);
        check({name, "_keyb_char"}, keyb_char, DBITS'(m_held));
        check({name, "_frame_errors"}, 32'(frame_errors), 32'(m_err));
        check({name, "_pending_events"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic model_reset();
        m_held = '0;
        m_ext  = 1'b0;
        m_brk  = 1'b0;
        m_err  = 0;
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] pool [8];
        logic [7:0] b;
        pool = '{8'hE0, 8'hF0, 8'h1C, 8'h29, 8'h75, 8'h12, 8'hAA, 8'hFA};

        #2 reset_n = 1'b0;
        wait_cycles(3);
        #1;
        check("reset_keyb_char", keyb_char, '0);
        check("reset_key_event", 32'(key_event), 32'd0);
        check("reset_frame_errors", 32'(frame_errors), 32'd0);
        reset_n = 1'b1;
        wait_cycles(5);

        send_frame(8'h1C, 0, 0);  check_state("make_1c");
        send_frame(8'hF0, 0, 0);
        send_frame(8'h1C, 0, 0);  check_state("break_1c");

        send_frame(8'hE0, 0, 0);
        send_frame(8'h75, 0, 0);  check_state("make_e075");
        check("ext_value", keyb_char, 32'h175);
        send_frame(8'hE0, 0, 0);
        send_frame(8'hF0, 0, 0);
        send_frame(8'h75, 0, 0);  check_state("break_e075");
        send_frame(8'hE0, 0, 0);
        send_frame(8'h75, 0, 0);
        send_frame(8'hF0, 0, 0);
        send_frame(8'h75, 0, 0);  check_state("break_no_ext");

        send_frame(8'h1C, 0, 0);
        send_frame(8'h29, 0, 0);
        send_frame(8'hF0, 0, 0);
        send_frame(8'h1C, 0, 0);  check_state("nonmatch_break");
        send_frame(8'h29, 0, 0);  check_state("typematic");

        send_frame(8'h1C, 1, 0);  check_state("bad_parity");
        send_frame(8'h1C, 0, 1);  check_state("bad_stop");

        // Partial frame abandoned long enough for the watchdog to fire.
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'(i & 1));
        ps2_data = 1'b1;
        m_err++;
        wait_cycles(TMO + 10);
        check_state("timeout");
        send_frame(8'h29, 0, 0);  check_state("after_timeout");

        // Reset in the middle of a frame.
        send_frame(8'h12, 0, 0);
        send_bit(1'b0);
        send_bit(1'b1);
        ps2_data = 1'b0;
        wait_cycles(10);
        ps2_clk = 1'b0;
        wait_cycles(5);
        reset_n = 1'b0;
        #1;
        model_reset();
        check("midreset_keyb_char", keyb_char, '0);
        check("midreset_key_event", 32'(key_event), 32'd0);
        check("midreset_frame_errors", 32'(frame_errors), 32'd0);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        wait_cycles(5);
        reset_n = 1'b1;
        wait_cycles(20);
        send_frame(8'h1C, 0, 0);  check_state("after_reset");

        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 9))
                8:       b = 8'($urandom);
                9:       b = m_held[7:0];
                default: b = pool[$urandom_range(0, 7)];
            endcase
            send_frame(b, ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0));
            check_state("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
